key_load_ctrl: RTL and testbench
================================

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

Interface
REQ-001 Parameter MAX_FAIL, default 3: failed load attempts before permanent lockout.
REQ-002 Parameter KEY_W, default 92: key bits per frame (88 X_ keys plus 4 p keys).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  serial key bit present.
REQ-006 in_bit  input  1  serial key/checksum bit.
REQ-007 in_ready  output  1  controller accepts a bit this cycle.
REQ-008 zeroize  input  1  synchronous request to discard the loaded key.
REQ-009 key_x  output  88  X_1..X_88 drive to the locked c432 netlist; key_x[0]=X_1.
REQ-010 key_p  output  4  p1..p4 drive; key_p[0]=p1.
REQ-011 key_ok  output  1  key armed and applied.
REQ-012 err  output  1  one-cycle pulse on checksum failure.
REQ-013 lockout  output  1  controller permanently locked.
REQ-014 fail_cnt  output  2  failed attempts since reset.

Function
REQ-015 States SHALL be IDLE, SHIFT, CHECK, ARMED and LOCKOUT.
REQ-016 A bit SHALL transfer only in a cycle where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 in IDLE and SHIFT and 0 in CHECK, ARMED and LOCKOUT.
REQ-018 A frame SHALL be 100 bits: indices 0..91 are key bits (0..87 to X_1..X_88, 88..91 to p1..p4), indices 92..99 are chk[0]..chk[7].
REQ-019 The expected checksum bit chk[i] SHALL be the XOR of all key bits k with k mod 8 = i, for k = 0..91.
REQ-020 The first transfer in IDLE SHALL store bit 0 and move to SHIFT; a 7-bit counter SHALL track the index.
REQ-021 The 100th transfer SHALL move to CHECK on the next edge; CHECK SHALL last exactly one cycle.
REQ-022 On a CHECK match, the next state SHALL be ARMED; key_ok=1 and key_x/key_p show the shadow key from the first ARMED cycle.
REQ-023 On a CHECK mismatch, fail_cnt SHALL increment and err SHALL pulse for one cycle (the cycle after CHECK).
REQ-024 After a mismatch, the next state SHALL be LOCKOUT if the incremented fail_cnt equals MAX_FAIL, otherwise IDLE with the shadow cleared.
REQ-025 key_x and key_p SHALL be 0 in every state except ARMED; partially shifted bits SHALL never reach the outputs.
REQ-026 A successful CHECK SHALL leave fail_cnt unchanged.
REQ-027 zeroize in IDLE, SHIFT, CHECK or ARMED SHALL, next edge, go to IDLE and clear the shadow, the counter, key_ok, key_x and key_p; fail_cnt is kept.
REQ-028 zeroize in CHECK SHALL take priority over the check result: no err pulse and no fail_cnt increment.
REQ-029 zeroize asserted together with a transfer SHALL discard that bit.
REQ-030 in_valid gaps in SHIFT SHALL hold state and the counter indefinitely.
REQ-031 LOCKOUT SHALL be exited only by rst; lockout=1 in that state, with outputs 0, in_ready 0 and zeroize ignored.
REQ-032 fail_cnt SHALL saturate at MAX_FAIL.

Reset
REQ-033 On rst: state IDLE, shadow key and bit counter cleared.
REQ-034 On rst: key_x=0, key_p=0, key_ok=0, err=0, lockout=0, fail_cnt=0.
REQ-035 rst asserted mid-frame or in LOCKOUT SHALL abort immediately with no err pulse.

Verification
REQ-036 Frame with X_1=1, all other key bits 0, chk=8'h01, contiguous valid -> key_ok=1 two cycles after the 100th transfer, key_x=88'h1, key_p=0.
REQ-037 Frame with only p4=1 (bit 91), chk=8'h08, in_valid toggling every other cycle -> ARMED, key_p=4'h8, key_x=0.
REQ-038 All-zero key with chk=8'h01, sent three times (MAX_FAIL=3) -> err pulses 3 times, fail_cnt 1,2,3, lockout=1, in_ready=0; a further valid frame is ignored; rst clears lockout.
REQ-039 Armed with X_1=1, then zeroize for one cycle -> next cycle key_ok=0, key_x=0, state IDLE, in_ready=1, fail_cnt unchanged.
REQ-040 rst pulsed after 50 transfers, then a full valid all-zero frame with chk=8'h00 -> ARMED with key_x=0, key_p=0, fail_cnt=0.
REQ-041 Bad frame with zeroize asserted in the CHECK cycle -> no err pulse, fail_cnt stays 0, state IDLE.

Source files
------------

// File: rtl/key_load_if.sv
// Serial key-load bus between a key source and key_load_ctrl.
// The master drives key bits and zeroize; the slave returns ready and the armed key.
interface key_load_if;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        zeroize;
  logic [87:0] key_x;
  logic [3:0]  key_p;
  logic        key_ok;
  logic        err;
  logic        lockout;
  logic [1:0]  fail_cnt;

  modport master (
    output in_valid, in_bit, zeroize,
    input  in_ready, key_x, key_p, key_ok, err, lockout, fail_cnt
  );

  modport slave (
    input  in_valid, in_bit, zeroize,
    output in_ready, key_x, key_p, key_ok, err, lockout, fail_cnt
  );
endinterface

// File: rtl/key_load_ctrl.sv
// Serial key loader for a logic-locked netlist: shifts a 100-bit frame into a shadow
// register, verifies its 8-bit interleaved parity, and drives the key only once armed.
module key_load_ctrl #(
  parameter int MAX_FAIL = 3,
  parameter int KEY_W    = 92
) (
  input  logic      clk,
  input  logic      rst,
  key_load_if.slave bus
);
  localparam int         FRAME_W    = KEY_W + 8;
  localparam logic [6:0] LAST_IDX   = 7'(FRAME_W - 1);
  localparam logic [1:0] FAIL_LIMIT = 2'(MAX_FAIL);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ARMED, LOCKOUT} state_t;

  state_t               state_reg, state_next;
  logic [6:0]           cnt_reg, cnt_next;
  logic [FRAME_W-1:0]   shadow_reg, shadow_next;
  logic [1:0]           fail_cnt_reg, fail_cnt_next;
  logic                 err_reg, err_next;
  logic [7:0]           chk_calc;
  logic [1:0]           fail_inc;
  logic                 ready;
  logic                 xfer;
  logic                 armed;

  // chk[i] is the parity of every key bit whose index is congruent to i mod 8
  for (genvar gi = 0; gi < 8; gi++) begin : g_chk
    logic par;
    always_comb begin
      par = 1'b0;
      for (int k = gi; k < KEY_W; k += 8) begin
        par = par ^ shadow_reg[k];
      end
    end
    assign chk_calc[gi] = par;
  end

  assign ready    = (state_reg == IDLE) || (state_reg == SHIFT);
  assign xfer     = bus.in_valid && ready;
  assign armed    = (state_reg == ARMED);
  assign fail_inc = (fail_cnt_reg == FAIL_LIMIT) ? fail_cnt_reg : fail_cnt_reg + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shadow_reg   <= '0;
      fail_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shadow_reg   <= shadow_next;
      fail_cnt_reg <= fail_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    shadow_next   = shadow_reg;
    fail_cnt_next = fail_cnt_reg;
    err_next      = 1'b0;

    case (state_reg)
      IDLE, SHIFT: begin
        // zeroize wins over a simultaneous transfer, so that bit is dropped
        if (bus.zeroize) begin
          state_next  = IDLE;
          cnt_next    = '0;
          shadow_next = '0;
        end else if (xfer) begin
          shadow_next[cnt_reg] = bus.in_bit;
          if (cnt_reg == LAST_IDX) begin
            state_next = CHECK;
            cnt_next   = '0;
          end else begin
            state_next = SHIFT;
            cnt_next   = cnt_reg + 7'd1;
          end
        end
      end
      CHECK: begin
        if (bus.zeroize) begin
          state_next  = IDLE;
          shadow_next = '0;
        end else if (chk_calc == shadow_reg[FRAME_W-1:KEY_W]) begin
          state_next = ARMED;
        end else begin
          fail_cnt_next = fail_inc;
          err_next      = 1'b1;
          shadow_next   = '0;
          state_next    = (fail_inc == FAIL_LIMIT) ? LOCKOUT : IDLE;
        end
      end
      ARMED: begin
        if (bus.zeroize) begin
          state_next  = IDLE;
          shadow_next = '0;
        end
      end
      LOCKOUT: state_next = LOCKOUT;
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = ready;
  assign bus.key_ok   = armed;
  assign bus.key_x    = armed ? shadow_reg[KEY_W-5:0] : '0;
  assign bus.key_p    = armed ? shadow_reg[KEY_W-1:KEY_W-4] : '0;
  assign bus.err      = err_reg;
  assign bus.lockout  = (state_reg == LOCKOUT);
  assign bus.fail_cnt = fail_cnt_reg;
endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed and randomized frames for key_load_ctrl, checked against a frame-level
// model that derives the checksum from key bits and tracks failed attempts.
module tb_key_load_ctrl;
  localparam int MAX_FAIL = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_fails;

  key_load_if kif ();

  key_load_ctrl #(.MAX_FAIL(MAX_FAIL), .KEY_W(92)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] calc_chk(input logic [91:0] key);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 92; k++) c[k % 8] = c[k % 8] ^ key[k];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    kif.in_valid = 1'b0;
    kif.in_bit   = 1'b0;
    kif.zeroize  = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    exp_fails = 0;
  endtask

  // Drives frame bits lo..hi, one per cycle; with gap set, idle cycles separate the bits.
  task automatic drive_bits(input logic [99:0] frame, input int lo, input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) begin
      kif.in_valid = 1'b1;
      kif.in_bit   = frame[i];
      tick();
      kif.in_valid = 1'b0;
      if (gap && i != 99) tick();
    end
    kif.in_valid = 1'b0;
  endtask

  // Called right after the 100th transfer: checks the CHECK cycle and the outcome after it.
  task automatic finish_check(input string tag, input logic [91:0] key, input logic [7:0] chk_sent,
                              input bit zero_in_check);
    bit good;
    bit locked;
    chk({tag, "_check_ready"}, kif.in_ready, 1'b0);
    chk({tag, "_check_keyok"}, kif.key_ok, 1'b0);
    kif.zeroize = zero_in_check;
    tick();
    kif.zeroize = 1'b0;
    good = (calc_chk(key) == chk_sent);
    if (zero_in_check) begin
      chk({tag, "_zero_err"}, kif.err, 1'b0);
      chk({tag, "_zero_keyok"}, kif.key_ok, 1'b0);
      chk({tag, "_zero_ready"}, kif.in_ready, 1'b1);
      chk({tag, "_zero_fail"}, kif.fail_cnt, exp_fails);
    end else if (good) begin
      chk({tag, "_keyok"}, kif.key_ok, 1'b1);
      chk({tag, "_key_x"}, kif.key_x, key[87:0]);
      chk({tag, "_key_p"}, kif.key_p, key[91:88]);
      chk({tag, "_err"}, kif.err, 1'b0);
      chk({tag, "_fail"}, kif.fail_cnt, exp_fails);
    end else begin
      if (exp_fails < MAX_FAIL) exp_fails++;
      locked = (exp_fails == MAX_FAIL);
      chk({tag, "_err"}, kif.err, 1'b1);
      chk({tag, "_fail"}, kif.fail_cnt, exp_fails);
      chk({tag, "_lockout"}, kif.lockout, locked);
      chk({tag, "_ready"}, kif.in_ready, !locked);
      chk({tag, "_keyok"}, kif.key_ok, 1'b0);
      chk({tag, "_key_x"}, kif.key_x, 88'h0);
    end
    tick();
    chk({tag, "_err_gone"}, kif.err, 1'b0);
  endtask

  task automatic zeroize_pulse(input string tag);
    int fails_before;
    fails_before = exp_fails;
    kif.zeroize = 1'b1;
    tick();
    kif.zeroize = 1'b0;
    chk({tag, "_zkeyok"}, kif.key_ok, 1'b0);
    chk({tag, "_zkey_x"}, kif.key_x, 88'h0);
    chk({tag, "_zkey_p"}, kif.key_p, 4'h0);
    chk({tag, "_zready"}, kif.in_ready, 1'b1);
    chk({tag, "_zfail"}, kif.fail_cnt, fails_before);
  endtask

  initial begin
    logic [91:0] key;
    logic [7:0]  csum;
    logic [95:0] rnd;
    logic [99:0] frame;
    bit          gap;
    total     = 0;
    bad       = 0;
    exp_fails = 0;
    rst       = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ready", kif.in_ready, 1'b1);
    chk("rst_keyok", kif.key_ok, 1'b0);
    chk("rst_err", kif.err, 1'b0);
    chk("rst_lockout", kif.lockout, 1'b0);
    chk("rst_fail", kif.fail_cnt, 2'd0);
    chk("rst_key_x", kif.key_x, 88'h0);

    // X_1 only, contiguous, then zeroize from ARMED
    key = 92'h1;
    frame = {calc_chk(key), key};
    chk("x1_model_chk", calc_chk(key), 8'h01);
    drive_bits(frame, 0, 99, 1'b0);
    finish_check("x1", key, 8'h01, 1'b0);
    zeroize_pulse("x1");

    // p4 only, in_valid toggling
    key = 92'h0;
    key[91] = 1'b1;
    frame = {8'h08, key};
    drive_bits(frame, 0, 99, 1'b1);
    finish_check("p4", key, 8'h08, 1'b0);
    zeroize_pulse("p4");

    // Partial frame must not reach outputs; long gap holds position
    key = {$urandom, $urandom, $urandom};
    frame = {calc_chk(key), key};
    drive_bits(frame, 0, 39, 1'b0);
    chk("part_key_x", kif.key_x, 88'h0);
    chk("part_keyok", kif.key_ok, 1'b0);
    kif.in_valid = 1'b0;
    repeat (20) tick();
    chk("gap_ready", kif.in_ready, 1'b1);
    drive_bits(frame, 40, 99, 1'b0);
    finish_check("gap", key, calc_chk(key), 1'b0);
    zeroize_pulse("gap");

    // Bad frame, zeroize in CHECK
    key = 92'h0;
    frame = {8'h01, key};
    drive_bits(frame, 0, 99, 1'b0);
    finish_check("zchk", key, 8'h01, 1'b1);

    // Randomized frames against the model
    for (int n = 0; n < 8; n++) begin
      rnd  = {$urandom, $urandom, $urandom};
      key  = rnd[91:0];
      csum = calc_chk(key);
      if ($urandom_range(0, 3) == 0) csum = csum ^ (8'h01 << $urandom_range(0, 7));
      gap   = 1'($urandom_range(0, 1));
      frame = {csum, key};
      drive_bits(frame, 0, 99, gap);
      finish_check($sformatf("rnd%0d", n), key, csum, 1'b0);
      if (exp_fails == MAX_FAIL) do_reset();
      else if (calc_chk(key) == csum) zeroize_pulse($sformatf("rnd%0d", n));
    end

    // Async reset after 50 transfers, then all-zero frame
    do_reset();
    frame = 100'h0;
    drive_bits(frame, 0, 49, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_ready", kif.in_ready, 1'b1);
    chk("arst_err", kif.err, 1'b0);
    tick();
    rst = 1'b0;
    exp_fails = 0;
    drive_bits(frame, 0, 99, 1'b0);
    finish_check("zero", 92'h0, 8'h00, 1'b0);
    zeroize_pulse("zero");

    // Three bad frames reach lockout
    do_reset();
    frame = {8'h01, 92'h0};
    for (int n = 0; n < 3; n++) begin
      drive_bits(frame, 0, 99, 1'b0);
      finish_check($sformatf("lock%0d", n), 92'h0, 8'h01, 1'b0);
    end
    chk("lock_state", kif.lockout, 1'b1);
    frame = 100'h0;
    drive_bits(frame, 0, 99, 1'b0);
    repeat (2) tick();
    chk("lock_ignore_frame", kif.lockout, 1'b1);
    chk("lock_ignore_keyok", kif.key_ok, 1'b0);
    chk("lock_ignore_ready", kif.in_ready, 1'b0);
    kif.zeroize = 1'b1;
    tick();
    kif.zeroize = 1'b0;
    chk("lock_ignore_zeroize", kif.lockout, 1'b1);
    chk("lock_fail_sat", kif.fail_cnt, 2'd3);
    do_reset();
    chk("unlock_lockout", kif.lockout, 1'b0);
    chk("unlock_fail", kif.fail_cnt, 2'd0);
    chk("unlock_ready", kif.in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
